// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared state encoding and mode constants for data_memory_dma
package dma_pkg;

    // Transfer engine states; encoding kept fixed so waveforms stay comparable
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/data_memory.sv
// rtl/data_memory.sv - single-port data memory, negedge write, combinational read
module data_memory #(
    parameter int D = 6,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         write_enable,
    input  logic [D-1:0] address,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] data_out
);

    logic [W-1:0] mem [0:(1<<D)-1];

    // Writes land on the falling edge so the engine can present address/data for a full half cycle
    always_ff @(negedge clk) begin
        if (write_enable) begin
            mem[address] <= data_in;
        end
    end

    assign data_out = mem[address];

endmodule

// File: rtl/data_memory_dma.sv
// rtl/data_memory_dma.sv - copy/fill engine driving the single-port data memory
module data_memory_dma
    import dma_pkg::*;
#(
    parameter int D = 6,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [D-1:0] src_base,
    input  logic [D-1:0] dst_base,
    input  logic [D:0]   length,
    input  logic [W-1:0] fill_value,
    output logic         busy,
    output logic         done,
    output logic         mem_write_enable,
    output logic [D-1:0] mem_address,
    output logic [W-1:0] mem_wdata,
    input  logic [W-1:0] mem_rdata
);

    localparam logic [D-1:0] PTR_ONE = D'(1);
    localparam logic [D:0]   CNT_ONE = (D+1)'(1);

    state_t       state;
    logic [D-1:0] src_ptr;
    logic [D-1:0] dst_ptr;
    logic [D:0]   cnt;
    logic [D:0]   len_reg;
    logic         mode_reg;
    logic [W-1:0] fill_reg;
    logic [W-1:0] data_buf;
    logic [D:0]   cnt_next;

    assign cnt_next = cnt + CNT_ONE;

    // Transfer sequencing: latch the request, alternate read/write (copy) or write only (fill)
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            src_ptr  <= '0;
            dst_ptr  <= '0;
            cnt      <= '0;
            len_reg  <= '0;
            mode_reg <= MODE_COPY;
            fill_reg <= '0;
            data_buf <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr  <= src_base;
                        dst_ptr  <= dst_base;
                        len_reg  <= length;
                        mode_reg <= mode;
                        fill_reg <= fill_value;
                        cnt      <= '0;
                        if (length == '0) begin
                            state <= DONE;
                        end else if (mode == MODE_FILL) begin
                            state <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    data_buf <= mem_rdata;
                    state    <= WRITE;
                end
                WRITE: begin
                    // Pointers wrap naturally at 2^D; overlapping copies re-read freshly written words
                    src_ptr <= src_ptr + PTR_ONE;
                    dst_ptr <= dst_ptr + PTR_ONE;
                    cnt     <= cnt_next;
                    if (cnt_next == len_reg) begin
                        state <= DONE;
                    end else if (mode_reg == MODE_FILL) begin
                        state <= WRITE;
                    end else begin
                        state <= READ;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory port and status decode; rst gates the write strobe so no negedge write happens during reset
    always_comb begin
        busy             = 1'b0;
        done             = 1'b0;
        mem_write_enable = 1'b0;
        mem_address      = '0;
        mem_wdata        = '0;
        unique case (state)
            READ: begin
                busy        = 1'b1;
                mem_address = src_ptr;
            end
            WRITE: begin
                busy             = 1'b1;
                mem_write_enable = !rst;
                mem_address      = dst_ptr;
                mem_wdata        = (mode_reg == MODE_FILL) ? fill_reg : data_buf;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_data_memory_dma.sv
// tb/tb_data_memory_dma.sv - self-checking bench for data_memory_dma with data_memory responder
module tb_data_memory_dma;

    localparam int D     = 6;
    localparam int W     = 32;
    localparam int DEPTH = 1 << D;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mode;
    logic [D-1:0] src_base;
    logic [D-1:0] dst_base;
    logic [D:0]   length;
    logic [W-1:0] fill_value;
    logic         busy;
    logic         done;
    logic         mem_write_enable;
    logic [D-1:0] mem_address;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata;

    logic         bd_sel;
    logic         bd_we;
    logic [D-1:0] bd_addr;
    logic [W-1:0] bd_wdata;
    logic         m_we;
    logic [D-1:0] m_addr;
    logic [W-1:0] m_wdata;

    logic [W-1:0] model [DEPTH];
    int           errors = 0;
    int           checks = 0;

    typedef struct {
        bit          md;
        int          src;
        int          dst;
        int          len;
        logic [31:0] fv;
        int          exp_busy;
        int          exp_done;
    } vec_t;

    always #5 clk = ~clk;

    data_memory_dma #(.D(D), .W(W)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .mode             (mode),
        .src_base         (src_base),
        .dst_base         (dst_base),
        .length           (length),
        .fill_value       (fill_value),
        .busy             (busy),
        .done             (done),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata)
    );

    assign m_we    = bd_sel ? bd_we    : mem_write_enable;
    assign m_addr  = bd_sel ? bd_addr  : mem_address;
    assign m_wdata = bd_sel ? bd_wdata : mem_wdata;

    data_memory #(.D(D), .W(W)) u_mem (
        .clk          (clk),
        .write_enable (m_we),
        .address      (m_addr),
        .data_in      (m_wdata),
        .data_out     (mem_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bd_write(input int addr, input logic [W-1:0] data);
        bd_sel   = 1'b1;
        bd_we    = 1'b1;
        bd_addr  = D'(addr);
        bd_wdata = data;
        @(negedge clk);
        #1;
        bd_we  = 1'b0;
        bd_sel = 1'b0;
    endtask

    task automatic init_mem();
        for (int i = 0; i < DEPTH; i++) begin
            bd_write(i, W'(i + 1));
            model[i] = W'(i + 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_mem(input string name);
        int          bad;
        int          first;
        logic [W-1:0] rd;
        bad   = 0;
        first = -1;
        for (int i = 0; i < DEPTH; i++) begin
            bd_sel  = 1'b1;
            bd_addr = D'(i);
            #1;
            rd = mem_rdata;
            if (rd !== model[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        bd_sel = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_mem: %0d words wrong, first at %0d", name, bad, first);
        end
        @(posedge clk);
        #1;
    endtask

    // Caller sits #1 after a posedge; one transfer is issued and observed for a bounded window
    task automatic run_xfer(input bit md, input int src, input int dst, input int len,
                            input logic [31:0] fv, input int exp_busy, input int exp_done,
                            input bit repulse, input string name);
        int bc, wc, dc, dcyc, alt_bad;
        bc = 0; wc = 0; dc = 0; dcyc = -1; alt_bad = 0;
        mode       = md;
        src_base   = D'(src);
        dst_base   = D'(dst);
        length     = (D+1)'(len);
        fill_value = fv;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        mode       = ~md;
        src_base   = D'($urandom);
        dst_base   = D'($urandom);
        length     = (D+1)'($urandom);
        fill_value = $urandom;
        for (int c = 1; c <= exp_done + 2; c++) begin
            if (busy) bc++;
            if (mem_write_enable) wc++;
            if (done) begin
                dc++;
                dcyc = c;
            end
            if (md == 1'b0 && c <= exp_busy && mem_write_enable != (c % 2 == 0)) alt_bad++;
            if (repulse && c == 3) begin
                start    = 1'b1;
                dst_base = D'(40);
                mode     = 1'b1;
                length   = (D+1)'(5);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check({name, "_busy_cycles"}, 64'(bc), 64'(exp_busy));
        check({name, "_done_pulses"}, 64'(dc), 64'd1);
        check({name, "_done_cycle"}, 64'(dcyc), 64'(exp_done));
        check({name, "_writes"}, 64'(wc), 64'(len));
        if (md == 1'b0) check({name, "_we_alternate"}, 64'(alt_bad), 64'd0);
        for (int i = 0; i < len; i++) begin
            if (md) model[(dst + i) % DEPTH] = fv;
            else    model[(dst + i) % DEPTH] = model[(src + i) % DEPTH];
        end
        check_mem(name);
    endtask

    initial begin
        vec_t vecs[6];
        int   len, eb, r;
        bit   md;

        vecs[0] = '{1'b1, 0, 4, 3, 32'hA5A5_A5A5, 3, 4};
        vecs[1] = '{1'b0, 0, 10, 4, 32'h0, 8, 9};
        vecs[2] = '{1'b1, 0, 62, 4, 32'h7, 4, 5};
        vecs[3] = '{1'b0, 5, 9, 0, 32'h0, 0, 1};
        vecs[4] = '{1'b0, 30, 32, 5, 32'h0, 10, 11};
        vecs[5] = '{1'b1, 0, 17, 64, 32'hDEAD_BEEF, 64, 65};

        rst = 1'b1; start = 1'b0; mode = 1'b0; src_base = '0; dst_base = '0;
        length = '0; fill_value = '0; bd_sel = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_we", 64'(mem_write_enable), 64'd0);
        check("reset_addr", 64'(mem_address), 64'd0);
        check("reset_wdata", 64'(mem_wdata), 64'd0);
        rst = 1'b0;
        init_mem();

        for (int v = 0; v < 6; v++) begin
            run_xfer(vecs[v].md, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].fv,
                     vecs[v].exp_busy, vecs[v].exp_done, 1'b0, $sformatf("vec%0d", v));
        end

        for (int k = 0; k < 25; k++) begin
            md = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 15);
            if (r == 15)      len = DEPTH;
            else if (r == 14) len = 0;
            else              len = $urandom_range(1, 12);
            eb = (len == 0) ? 0 : (md ? len : 2 * len);
            run_xfer(md, $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), len,
                     $urandom, eb, eb + 1, 1'b0, $sformatf("rnd%0d", k));
        end

        // start re-pulsed while busy must not disturb the running copy or touch mem[40]
        init_mem();
        run_xfer(1'b0, 0, 10, 4, 32'h0, 8, 9, 1'b1, "repulse");

        // reset asserted in the third write cycle of a copy
        init_mem();
        mode = 1'b0; src_base = D'(0); dst_base = D'(20); length = (D+1)'(8); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_pre_we", 64'(mem_write_enable), 64'd1);
        check("midrst_pre_addr", 64'(mem_address), 64'd22);
        rst = 1'b1;
        #1;
        check("midrst_we_blocked", 64'(mem_write_enable), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_addr", 64'(mem_address), 64'd0);
        model[20] = model[0];
        model[21] = model[1];
        check_mem("midrst");

        // reset while in DONE suppresses the pulse afterwards
        length = '0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("donerst_pre_done", 64'(done), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("donerst_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        check("donerst_done_next", 64'(done), 64'd0);
        check("donerst_busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_memory_dma.md
Name: data_memory_dma

Overview:
Memory-side initiator that drives the single-port data_memory interface: write_enable, address, write data, and combinational read data.
- Copy mode moves a block of words between two regions.
- Fill mode writes one constant value to a region.
- Sits between the processor's control logic and data_memory; the processor starts a transfer with a pulse and polls busy/done.
- Data memory writes on the negedge and reads combinationally. The engine therefore reads in one cycle and writes in the next.

Parameters:
D, 6, address width; memory depth is 2^D words, and must match the attached data_memory.
W, 32, word width in bits.

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
mode  in  1  0 = copy, 1 = fill
src_base  in  D  first source address (copy only)
dst_base  in  D  first destination address
length  in  D+1  word count, 0..2^D
fill_value  in  W  word written in fill mode
busy  out  1  high while a transfer is in progress
done  out  1  one-cycle pulse at completion
mem_write_enable  out  1  to data_memory write_enable
mem_address  out  D  to data_memory address
mem_wdata  out  W  to data_memory data_in
mem_rdata  in  W  from data_memory data_out (combinational)

Behaviour:
- States: IDLE, READ, WRITE, DONE.
- Reset: rst high at a posedge forces IDLE and clears all registers. Outputs after reset: busy=0, done=0, mem_write_enable=0, mem_address=0, mem_wdata=0.
- Write blocking during reset: mem_write_enable = (state==WRITE) && !rst. No negedge write can occur in any cycle where rst is high, including reset mid-operation.
- IDLE → start accepted (start=1): latch src_base, dst_base, length, mode and fill_value into registers; clear word counter.
  - length==0 → DONE.
  - mode=copy → READ.
  - mode=fill → WRITE.
- IDLE → start=0: stay in IDLE.
- READ:
  - Drive mem_address=src_ptr and mem_write_enable=0.
  - At posedge, capture mem_rdata into data_buf, then → WRITE.
- WRITE:
  - Drive mem_address=dst_ptr and mem_write_enable=1.
  - mem_wdata = data_buf (copy) or fill_reg (fill).
  - At posedge: src_ptr, dst_ptr and the counter increment.
  - If counter+1 == length → DONE; else → READ (copy) or WRITE (fill).
- DONE: done=1 and busy=0 for exactly one cycle, then → IDLE.
- busy = state is READ or WRITE.
- mem_address=0 and mem_wdata=0 in IDLE and DONE.
- Latency from the start-accept edge:
  - Copy of N words: 2N busy cycles, done in cycle 2N+1.
  - Fill of N words: N busy cycles, done in cycle N+1.
  - length 0: done in cycle 1, no writes, busy never high.
- Address arithmetic: pointers are D bits and wrap modulo 2^D (63+1 → 0 at D=6). length=2^D covers the whole memory.
- Overlap: copy is strictly ascending, word by word (read then write). With dst inside (src, src+N) the earlier-written words are re-read ("smear"). This is the defined behaviour, not an error.
- start while busy or in DONE: ignored, with no effect on the running transfer.
- Input changes after acceptance: src_base, dst_base, length, mode and fill_value have no effect until the next accepted start.
- Reset in DONE: done is suppressed in the following cycle.

Decomposition:
- Package dma_pkg:
  - state_t enum (IDLE, READ, WRITE, DONE).
  - Constants MODE_COPY=1'b0 and MODE_FILL=1'b1.
- No sub-module; pointer and counter logic stay inline.
- The bench instantiates data_memory as the responder.

Test Plan:
- Fill: mode=1, dst_base=4, length=3, fill_value=32'hA5A5_A5A5 → mem[4..6]=A5A5A5A5, mem[3] and mem[7] unchanged; busy 3 cycles; done in cycle 4.
- Copy: preload mem[0..3]=1,2,3,4; src=0, dst=10, length=4 → mem[10..13]=1,2,3,4; busy 8 cycles; done in cycle 9; mem_write_enable high only in alternate cycles.
- Wrap: fill dst_base=62, length=4, value 7 → mem[62], mem[63], mem[0], mem[1] = 7; mem[2] unchanged.
- length=0 with start → done pulse in cycle 1, busy never high, no mem_write_enable assertion.
- Reset mid-copy: src=0, dst=20, length=8; assert rst during the 3rd WRITE cycle (word index 2) → mem_write_enable low in that cycle; mem[20..21] copied, mem[22..27] unchanged; busy=0 and done=0 after the edge.
- start re-pulsed during busy with different dst_base=40 → original transfer completes unchanged; mem[40] untouched; a single done pulse.
